// File: rtl/sha256_w_sched_ctrl_if.sv
// Handshake bundle between a message-block producer and the SHA-256
// message-schedule controller. The controller uses the slave view.
interface sha256_w_sched_ctrl_if;
  logic         abort;
  logic         blk_valid;
  logic [511:0] blk_in;
  logic         blk_ready;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  modport master (
    output abort, blk_valid, blk_in, w_ready,
    input  blk_ready, w_valid, w_out, w_idx, w_last, busy
  );

  modport slave (
    input  abort, blk_valid, blk_in, w_ready,
    output blk_ready, w_valid, w_out, w_idx, w_last, busy
  );
endinterface

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message schedule generator: accepts one 512-bit block, then
// streams W0..W63 over a valid/ready handshake using a 16-word window.
module sha256_w_sched_ctrl (
  input  logic                 CLK,
  input  logic                 RST,
  sha256_w_sched_ctrl_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  idx_q, idx_d;
  logic [31:0] w_new;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next schedule word W[t+16] from the window holding W[t]..W[t+15].
  always_comb begin
    w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  end

  // Next-state, window load/shift and index update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        // abort is ignored here, so abort+blk_valid still loads the block
        if (bus.blk_valid) begin
          state_d = EMIT;
          idx_d   = '0;
          for (int unsigned i = 0; i < 16; i++) begin
            win_d[i] = bus.blk_in[511 - 32*i -: 32];
          end
        end
      end
      EMIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.w_ready) begin
          for (int unsigned i = 0; i < 15; i++) begin
            win_d[i] = win_q[i + 1];
          end
          win_d[15] = w_new;
          // index parks at 63 on the final transfer rather than wrapping
          if (idx_q == 6'd63) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, window and index registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus.blk_ready = (state_q == IDLE);
    bus.w_valid   = (state_q == EMIT);
    bus.busy      = (state_q != IDLE);
    bus.w_out     = win_q[0];
    bus.w_idx     = idx_q;
    bus.w_last    = (state_q == EMIT) && (idx_q == 6'd63);
  end

endmodule

// File: doc/sha256_w_sched_ctrl.md
SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 The block SHALL have no parameters; round count fixed at 64, word width fixed at 32.
REQ-002 The block SHALL provide port CLK, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL provide port RST, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL provide port abort, input, 1, synchronous cancel of the block in progress.
REQ-005 The block SHALL provide port blk_valid, input, 1, the 512-bit message block is valid.
REQ-006 The block SHALL provide port blk_in, input, 512, message block; W0 = blk_in[511:480], W15 = blk_in[31:0].
REQ-007 The block SHALL provide port blk_ready, output, 1, the block can accept a message block.
REQ-008 The block SHALL provide port w_valid, output, 1, w_out holds a valid schedule word.
REQ-009 The block SHALL provide port w_ready, input, 1, the consumer accepts w_out.
REQ-010 The block SHALL provide port w_out, output, 32, current schedule word W[w_idx].
REQ-011 The block SHALL provide port w_idx, output, 6, index of w_out (0..63).
REQ-012 The block SHALL provide port w_last, output, 1, high while w_valid is high and w_idx is 63.
REQ-013 The block SHALL provide port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have two states: IDLE and EMIT.
REQ-015 In IDLE, the block SHALL drive blk_ready=1 and w_valid=0.
REQ-016 In EMIT, the block SHALL drive blk_ready=0 and w_valid=1; blocks never overlap.
REQ-017 When blk_valid and blk_ready are both high, the block SHALL load W0..W15 into a 16-entry window, set the index to 0 and enter EMIT on the next cycle.
REQ-018 First-word latency SHALL be 1 cycle: w_valid rises on the cycle after block acceptance, with w_out=W0.
REQ-019 w_out SHALL equal window entry 0, and w_idx SHALL equal the index counter.
REQ-020 A word SHALL transfer only in a cycle where w_valid and w_ready are both high.
REQ-021 On each transfer, the window SHALL shift by one entry and append the new entry 15 as win[14]'s sigma1 + win[9] + win[1]'s sigma0 + win[0], summed mod 2^32.
REQ-022 The new entry SHALL equal W[t+16] for the t just transferred.
REQ-023 On each transfer, the index SHALL increment by 1.
REQ-024 sigma0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3.
REQ-025 sigma1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-026 While w_valid=1 and w_ready=0, w_out, w_idx, w_last and the window SHALL hold stable; there is no limit on stall length.
REQ-027 With w_ready held high, the block SHALL deliver one word per cycle: 64 words in 64 consecutive cycles.
REQ-028 On the transfer of W63, the FSM SHALL return to IDLE, with blk_ready=1 on the next cycle.
REQ-029 A block offered in that same cycle SHALL NOT be accepted, because blk_ready is 0 in EMIT.
REQ-030 The index counter SHALL never wrap past 63.
REQ-031 abort=1 SHALL force IDLE on the next cycle regardless of w_ready, and the in-flight word SHALL NOT count as transferred.
REQ-032 In IDLE, abort SHALL have no effect.
REQ-033 If abort and blk_valid are both high in IDLE, the block SHALL accept blk_in.
REQ-034 blk_in SHALL be sampled only in the cycle of acceptance, so later changes have no effect.

Reset
REQ-035 When RST=1 at a clock edge, the block SHALL enter IDLE.
REQ-036 After reset, outputs SHALL be w_valid=0, blk_ready=1, busy=0, w_last=0, w_idx=0 and w_out=0.
REQ-037 RST SHALL take priority over abort, blk_valid and w_ready.
REQ-038 Reset in the middle of a block SHALL discard the window with no further words emitted.
REQ-039 The window contents after reset SHALL be 0.

Verification
REQ-040 Scenario: "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; all 64 words are compared against the reference model; w_last is high only at w_idx=63; busy=0 in the next cycle.
REQ-041 Scenario: random block, w_ready toggled randomly -> the word sequence is identical to the w_ready=1 run, and w_out/w_idx stay stable during every stall.
REQ-042 Scenario: blk_valid held high continuously -> the second block is accepted exactly 1 cycle after the W63 transfer, and the first block's words are not corrupted.
REQ-043 Scenario: abort pulsed at w_idx=20 -> IDLE on the next cycle, and a new block then starts cleanly at w_idx=0 with correct words.
REQ-044 Scenario: RST asserted at w_idx=40 with abort=1 -> the reset values of REQ-036 appear on the next cycle, and no w_valid is seen until a new block is accepted.
REQ-045 Scenario: back-to-back blocks of all-ones and all-zeros -> the all-zeros block produces all-zero words, and the all-ones block matches the model, confirming mod-2^32 wrap.
